inst_fetch_ctrl: RTL and testbench

- Sequences the word-addressed, combinational-read instruction memory for the RV32 core.
- Owns the fetch PC and drives the memory address each cycle.
- Captures each returned word, with its PC, into a small fetch queue.
- Hands queue entries to decode over a valid/ready handshake; handles start, branch/jump redirect, halt on ECALL/EBREAK, and out-of-range address faults.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/inst_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] OP_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] OP_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a single-cycle flush.
// Latency: a pushed entry can appear at the head one cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers, occupancy and storage; flush discards everything after any pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is zeroed on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads imem, queues words for decode.
// Latency: a word fetched in cycle t is visible on inst in cycle t+1 at the earliest.
// Backpressure: full queue without a pop stalls fetch; fetch_pc holds, nothing is pushed.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           DEPTH    = 2,
  parameter int           INST_NUM = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] imem_adr,
  input  logic [N-1:0] imem_data,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [N-1:0] inst,
  output logic [N-1:0] inst_pc,
  output logic         halted,
  output logic         fault
);

  localparam logic [N-1:0] INST_LIM = N'(INST_NUM);

  fetch_state_e state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;

  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_in;
  fetch_entry_t q_head;
  logic [N-1:0] word_idx;
  logic         addr_fault;
  logic         can_fetch;
  logic         is_stop_op;

  assign imem_adr   = fetch_pc_q;
  assign inst_valid = !q_empty;
  assign inst       = N'(q_head.inst);
  assign inst_pc    = N'(q_head.pc);
  assign halted     = (state_q == HALT);
  assign fault      = (state_q == FAULT);

  assign q_pop      = !q_empty && inst_ready;
  // A slot is available if the queue has room or the head leaves this cycle.
  assign can_fetch  = !q_full || q_pop;
  assign word_idx   = {2'b00, fetch_pc_q[N-1:2]};
  assign addr_fault = (fetch_pc_q[1:0] != 2'b00) || (word_idx >= INST_LIM);
  assign is_stop_op = (imem_data == N'(OP_ECALL)) || (imem_data == N'(OP_EBREAK));
  assign q_in.pc    = XLEN'(fetch_pc_q);
  assign q_in.inst  = XLEN'(imem_data);

  // Next state: redirect beats the fault check, which beats fetch and halt detection.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          q_flush    = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (can_fetch) begin
          if (addr_fault) begin
            state_d = FAULT;
          end else begin
            q_push     = 1'b1;
            fetch_pc_d = fetch_pc_q + N'(4);
            if (is_stop_op) begin
              state_d = HALT;
            end
          end
        end
      end
      HALT, FAULT: begin
        if (redirect_valid) begin
          q_flush    = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_dat (q_in),
    .pop      (q_pop),
    .flush    (q_flush),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus randomized run vs a queue model.
// Latency: outputs compared on the falling edge, half a cycle after each rising edge.
// Backpressure: inst_ready is driven both directed and randomly.
module tb_inst_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam int          INST_NUM = 50;
  localparam logic [31:0] W_ECALL  = 32'h0000_0073;
  localparam logic [31:0] W_EBREAK = 32'h0010_0073;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_adr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  logic [31:0] mem [0:63];

  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: plain queue of (pc, word) plus a state code and next fetch address.
  int          mstate;
  logic [31:0] mpc;
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];

  always #5 clk = ~clk;

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_adr < 32'd256) imem_data = mem[imem_adr[7:2]];
  end

  inst_fetch_ctrl #(
    .N        (32),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH),
    .INST_NUM (INST_NUM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_adr       (imem_adr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted),
    .fault          (fault)
  );

  task automatic model_reset();
    mstate = M_IDLE;
    mpc    = 32'h0;
    q_pc.delete();
    q_in.delete();
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, land on the next falling edge.
  task automatic tick(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] w;
    start = s; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    if (q_pc.size() != 0 && rdy) begin
      w = q_pc.pop_front();
      w = q_in.pop_front();
    end
    if (mstate == M_IDLE) begin
      if (s) mstate = M_RUN;
    end else if (rv) begin
      q_pc.delete(); q_in.delete();
      mpc = rpc; mstate = M_RUN;
    end else if (mstate == M_RUN && q_pc.size() < DEPTH) begin
      if ((mpc % 4) != 0 || (mpc >> 2) >= 32'(INST_NUM)) begin
        mstate = M_FAULT;
      end else begin
        w = mem[mpc[7:2]];
        q_pc.push_back(mpc); q_in.push_back(w);
        mpc = mpc + 32'd4;
        if (w == W_ECALL || w == W_EBREAK) mstate = M_HALT;
      end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0010_2103;
    mem[2] = 32'h0011_01B3;
    mem[3] = W_EBREAK;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    #12;
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_vec++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_vec++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_vec++; if (halted !== 1'b0 || fault !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", halted, fault); end
    n_vec++; if (imem_adr !== 32'h0) begin n_bad++; $display("FAIL reset_adr: got %h want 0", imem_adr); end
  endtask

  task automatic test_start_stream();
    logic [31:0] exp_w [3];
    apply_reset();
    exp_w[0] = 32'h0000_2083; exp_w[1] = 32'h0010_2103; exp_w[2] = 32'h0011_01B3;
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b0 || imem_adr !== 32'h0) begin n_bad++; $display("FAIL idle_no_fetch: got v=%b adr=%h want v=0 adr=0", inst_valid, imem_adr); end
    tick(1'b1, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL first_run_cycle_valid: got %b want 0", inst_valid); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (inst_valid !== 1'b1 || inst !== exp_w[i] || inst_pc !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stream_%0d: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h", i, inst_valid, inst, inst_pc, exp_w[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] obs [$];
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b0);
    repeat (5) tick(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || inst !== 32'h0000_2083 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head_hold: got v=%b inst=%h pc=%h want 1 00002083 0", inst_valid, inst, inst_pc); end
    n_vec++; if (imem_adr !== 32'h8) begin n_bad++; $display("FAIL bp_adr_hold: got %h want 8", imem_adr); end
    for (int i = 0; i < 6; i++) begin
      if (inst_valid) obs.push_back(inst_pc);
      tick(1'b0, 1'b0, '0, 1'b1);
    end
    n_vec++; if (obs.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", obs.size()); end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      n_vec++; if (obs[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_order_%0d: got %h want %h", i, obs[i], 32'(4 * i)); end
    end
    n_vec++; if (halted !== 1'b1 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got h=%b v=%b want 1 0", halted, inst_valid); end
  endtask

  task automatic test_redirect();
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (imem_adr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h4) begin n_bad++; $display("FAIL redir_pre: got adr=%h v=%b pc=%h want 8 1 4", imem_adr, inst_valid, inst_pc); end
    tick(1'b0, 1'b1, 32'h20, 1'b1);
    n_vec++; if (inst_valid !== 1'b0 || imem_adr !== 32'h20) begin n_bad++; $display("FAIL redir_flush: got v=%b adr=%h want 0 20", inst_valid, imem_adr); end
    tick(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== mem[8]) begin n_bad++; $display("FAIL redir_target: got v=%b pc=%h inst=%h want 1 20 %h", inst_valid, inst_pc, inst, mem[8]); end
    // Redirect with a full queue and no pop: everything is discarded.
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 32'h4, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin n_bad++; $display("FAIL redir_full: got v=%b pc=%h want 1 4", inst_valid, inst_pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (halted !== 1'b1 || imem_adr !== 32'h10) begin n_bad++; $display("FAIL halt_enter: got h=%b adr=%h want 1 10", halted, imem_adr); end
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC || inst !== W_EBREAK) begin n_bad++; $display("FAIL halt_word: got v=%b pc=%h inst=%h want 1 c 00100073", inst_valid, inst_pc, inst); end
    repeat (2) tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (halted !== 1'b1 || imem_adr !== 32'h10 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL halt_frozen: got h=%b adr=%h v=%b want 1 10 0", halted, imem_adr, inst_valid); end
    tick(1'b0, 1'b1, 32'h0, 1'b1);
    n_vec++; if (halted !== 1'b0 || imem_adr !== 32'h0) begin n_bad++; $display("FAIL halt_resume: got h=%b adr=%h want 0 0", halted, imem_adr); end
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL halt_refetch: got v=%b pc=%h want 1 0", inst_valid, inst_pc); end
  endtask

  task automatic test_fault();
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b1, 32'hC8, 1'b1);
    n_vec++; if (fault !== 1'b0 || imem_adr !== 32'hC8) begin n_bad++; $display("FAIL fault_pre: got f=%b adr=%h want 0 c8", fault, imem_adr); end
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_adr !== 32'hC8) begin n_bad++; $display("FAIL fault_range: got f=%b v=%b adr=%h want 1 0 c8", fault, inst_valid, imem_adr); end
    tick(1'b0, 1'b1, 32'h2, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_adr !== 32'h2) begin n_bad++; $display("FAIL fault_align: got f=%b v=%b adr=%h want 1 0 2", fault, inst_valid, imem_adr); end
    tick(1'b0, 1'b1, 32'h0, 1'b1);
    n_vec++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b want 0", fault); end
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || fault !== 1'b0) begin n_bad++; $display("FAIL fault_refetch: got v=%b pc=%h f=%b want 1 0 0", inst_valid, inst_pc, fault); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
    n_vec++; if (inst_valid !== 1'b1 || imem_adr !== 32'h8) begin n_bad++; $display("FAIL arst_pre: got v=%b adr=%h want 1 8", inst_valid, imem_adr); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (inst_valid !== 1'b0 || imem_adr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL arst_now: got v=%b adr=%h inst=%h pc=%h want all 0", inst_valid, imem_adr, inst, inst_pc); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b0 || imem_adr !== 32'h0) begin n_bad++; $display("FAIL arst_idle: got v=%b adr=%h want 0 0", inst_valid, imem_adr); end
    tick(1'b1, 1'b0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL arst_restart: got v=%b pc=%h want 1 0", inst_valid, inst_pc); end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rpc;
    int          sel;
    for (int i = 0; i < 64; i++) begin
      sel = int'($urandom_range(0, 15));
      mem[i] = (sel == 0) ? W_ECALL : (sel == 1) ? W_EBREAK : ($urandom() | 32'h3);
    end
    apply_reset();
    tick(1'b1, 1'b0, '0, 1'b1);
    for (int c = 0; c < 800; c++) begin
      rv  = ($urandom_range(0, 9) == 0);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 1) rpc = 32'($urandom_range(50, 63)) << 2;
      else rpc = 32'($urandom_range(0, 49)) << 2;
      tick(1'($urandom_range(0, 1)), rv, rpc, ($urandom_range(0, 3) != 0));
      n_vec++; if (inst_valid !== (q_pc.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, inst_valid, q_pc.size() != 0); end
      if (q_pc.size() != 0) begin
        n_vec++; if (inst !== q_in[0] || inst_pc !== q_pc[0]) begin n_bad++; $display("FAIL rnd_head c=%0d: got %h@%h want %h@%h", c, inst, inst_pc, q_in[0], q_pc[0]); end
      end
      n_vec++; if (imem_adr !== mpc) begin n_bad++; $display("FAIL rnd_adr c=%0d: got %h want %h", c, imem_adr, mpc); end
      n_vec++; if (halted !== (mstate == M_HALT) || fault !== (mstate == M_FAULT)) begin n_bad++; $display("FAIL rnd_flags c=%0d: got h=%b f=%b want state %0d", c, halted, fault, mstate); end
    end
  endtask

  initial begin
    init_mem();
    model_reset();
    test_reset();
    test_start_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_fault();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
